// File: rtl/hue_operand_gen.sv
// RGB-to-HSV hue operand stage: max/min/chroma, sector pick and divider operands.
// Optional macro HUE_ZERO_DELTA_GUARD_EN: when delta is 0, forces O_B=1 and O_A=0.
module hue_operand_gen #(
  parameter int WIDTH = 8
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic [WIDTH-1:0]   I_R,
  input  logic [WIDTH-1:0]   I_G,
  input  logic [WIDTH-1:0]   I_B_CH,
  input  logic               I_VALID,
  output logic               O_READY,
  output logic [WIDTH+5:0]   O_A,
  output logic [WIDTH-1:0]   O_B,
  output logic [1:0]         O_SECTOR,
  output logic               O_NEG,
  output logic [WIDTH-1:0]   O_V,
  output logic               O_VALID,
  input  logic               I_READY
);

  localparam int A_WIDTH = WIDTH + 6;

  localparam logic [1:0] SEC_R = 2'd0;
  localparam logic [1:0] SEC_G = 2'd1;
  localparam logic [1:0] SEC_B = 2'd2;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_max;
  logic [WIDTH-1:0]   s1_min;
  logic [1:0]         s1_sector;
  // Two's-complement difference; the msb is the sign.
  logic [WIDTH:0]     s1_diff;

  logic               s1_adv;
  logic               s2_adv;

  logic [WIDTH-1:0]   in_max;
  logic [WIDTH-1:0]   in_min;
  logic [1:0]         in_sector;
  logic [WIDTH:0]     in_diff;

  logic [WIDTH:0]     diff_abs;
  logic [A_WIDTH-1:0] abs_ext;
  logic [A_WIDTH-1:0] num;
  logic [WIDTH-1:0]   delta;
  logic [WIDTH-1:0]   den;

  assign s2_adv  = !O_VALID || I_READY;
  assign s1_adv  = !s1_valid || s2_adv;
  assign O_READY = s1_adv;

  // Ties resolve toward R, then G, so a gray pixel lands in sector 0 with diff 0.
  always_comb begin
    in_max = I_R;
    if (I_G > in_max)    in_max = I_G;
    if (I_B_CH > in_max) in_max = I_B_CH;
    in_min = I_R;
    if (I_G < in_min)    in_min = I_G;
    if (I_B_CH < in_min) in_min = I_B_CH;
    if (in_max == I_R) begin
      in_sector = SEC_R;
      in_diff   = {1'b0, I_G} - {1'b0, I_B_CH};
    end else if (in_max == I_G) begin
      in_sector = SEC_G;
      in_diff   = {1'b0, I_B_CH} - {1'b0, I_R};
    end else begin
      in_sector = SEC_B;
      in_diff   = {1'b0, I_R} - {1'b0, I_G};
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      s1_valid  <= 1'b0;
      s1_max    <= '0;
      s1_min    <= '0;
      s1_sector <= SEC_R;
      s1_diff   <= '0;
    end else if (s1_adv) begin
      s1_valid  <= I_VALID && O_READY;
      s1_max    <= in_max;
      s1_min    <= in_min;
      s1_sector <= in_sector;
      s1_diff   <= in_diff;
    end
  end

  // 60*|diff| built from two shifts so no multiplier is inferred.
  always_comb begin
    diff_abs = s1_diff[WIDTH] ? (~s1_diff + {{WIDTH{1'b0}}, 1'b1}) : s1_diff;
    abs_ext  = {{(A_WIDTH-WIDTH-1){1'b0}}, diff_abs};
    num      = (abs_ext << 6) - (abs_ext << 2);
    delta    = s1_max - s1_min;
    den      = delta;
`ifdef HUE_ZERO_DELTA_GUARD_EN
    if (delta == '0) begin
      den = {{(WIDTH-1){1'b0}}, 1'b1};
      num = '0;
    end
`else
`endif
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_VALID  <= 1'b0;
      O_A      <= '0;
      O_B      <= '0;
      O_SECTOR <= SEC_R;
      O_NEG    <= 1'b0;
      O_V      <= '0;
    end else if (s2_adv) begin
      O_VALID  <= s1_valid;
      O_A      <= num;
      O_B      <= den;
      O_SECTOR <= s1_sector;
      O_NEG    <= s1_diff[WIDTH];
      O_V      <= s1_max;
    end
  end

endmodule

// File: tb/tb_hue_operand_gen.sv
// Directed self-checking bench for hue_operand_gen: reset, latency, sectors,
// ties, full-scale, backpressure and mid-stream reset.
module tb_hue_operand_gen;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [13:0] a;
    logic [7:0]  bd;
    logic [1:0]  sec;
    logic        neg;
    logic [7:0]  v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  inR, inG, inB;
  logic        inValid;
  logic        outReady;
  logic [13:0] outA;
  logic [7:0]  outB;
  logic [1:0]  outSector;
  logic        outNeg;
  logic [7:0]  outV;
  logic        outValid;
  logic        inReady;

  int errors = 0;
  int checks = 0;
  vec_t vecs [12];

  always #5 clk = ~clk;

  hue_operand_gen #(.WIDTH(8)) dut (
    .I_CLK(clk), .I_NRESET(rstN),
    .I_R(inR), .I_G(inG), .I_B_CH(inB), .I_VALID(inValid),
    .O_READY(outReady), .O_A(outA), .O_B(outB), .O_SECTOR(outSector),
    .O_NEG(outNeg), .O_V(outV), .O_VALID(outValid), .I_READY(inReady)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] expDenom(input int idx);
`ifdef HUE_ZERO_DELTA_GUARD_EN
    if (vecs[idx].bd == 8'd0) return 8'd1;
`endif
    return vecs[idx].bd;
  endfunction

  task automatic checkPixel(input int idx);
    checkOutput($sformatf("v%0d_A", idx),   64'(outA),      64'(vecs[idx].a));
    checkOutput($sformatf("v%0d_B", idx),   64'(outB),      64'(expDenom(idx)));
    checkOutput($sformatf("v%0d_sec", idx), 64'(outSector), 64'(vecs[idx].sec));
    checkOutput($sformatf("v%0d_neg", idx), 64'(outNeg),    64'(vecs[idx].neg));
    checkOutput($sformatf("v%0d_V", idx),   64'(outV),      64'(vecs[idx].v));
  endtask

  task automatic driveVec(input int idx);
    inR = vecs[idx].r;
    inG = vecs[idx].g;
    inB = vecs[idx].b;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 64'(outValid),  64'd0);
    checkOutput({tag, "_A"},     64'(outA),      64'd0);
    checkOutput({tag, "_B"},     64'(outB),      64'd0);
    checkOutput({tag, "_sec"},   64'(outSector), 64'd0);
    checkOutput({tag, "_neg"},   64'(outNeg),    64'd0);
    checkOutput({tag, "_V"},     64'(outV),      64'd0);
    checkOutput({tag, "_ready"}, 64'(outReady),  64'd1);
  endtask

  // Single pixel into an empty pipe: output valid after the second rising edge.
  task automatic latencyTest(input int idx);
    @(negedge clk);
    inReady = 1'b1;
    inValid = 1'b1;
    driveVec(idx);
    #1 checkOutput("lat_ready", 64'(outReady), 64'd1);
    @(negedge clk);
    inValid = 1'b0;
    #1 checkOutput("lat_early", 64'(outValid), 64'd0);
    @(negedge clk);
    #1 checkOutput("lat_valid", 64'(outValid), 64'd1);
    checkPixel(idx);
    @(negedge clk);
    #1 checkOutput("lat_single", 64'(outValid), 64'd0);
  endtask

  // Streams vectors first..first+count-1 with I_VALID held high, optionally
  // dropping I_READY for stallLen cycles; outputs are matched in order.
  task automatic applyStimulus(input int first, input int count, input int stallStart, input int stallLen);
    int q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic prevStall = 1'b0;
    logic sawReadyLow = 1'b0;
    logic [32:0] snapshot = '0;
    while (got < count && cyc < 300) begin
      @(negedge clk);
      cyc++;
      inReady = !(cyc >= stallStart && cyc < stallStart + stallLen);
      #1;
      if (outValid && !inReady) begin
        if (prevStall)
          checkOutput("stall_hold", 64'({outA, outB, outSector, outNeg, outV}), 64'(snapshot));
        snapshot  = {outA, outB, outSector, outNeg, outV};
        prevStall = 1'b1;
        if (!outReady) sawReadyLow = 1'b1;
      end else begin
        prevStall = 1'b0;
        if (outValid) begin
          if (q.size() == 0) checkOutput("unexpected_out", 64'd1, 64'd0);
          else checkPixel(q.pop_front());
          got++;
        end
      end
      if (sent < count) begin
        inValid = 1'b1;
        driveVec(first + sent);
        if (outReady) begin
          q.push_back(first + sent);
          sent++;
        end
      end else begin
        inValid = 1'b0;
      end
    end
    inValid = 1'b0;
    inReady = 1'b1;
    checkOutput("stream_count", 64'(got), 64'(count));
    if (stallLen > 0) checkOutput("ready_dropped", 64'(sawReadyLow), 64'd1);
    repeat (3) begin
      @(negedge clk);
      #1 checkOutput("no_extra", 64'(outValid), 64'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{8'd200, 8'd100, 8'd50,  14'd3000,  8'd150, 2'd0, 1'b0, 8'd200};
    vecs[1]  = '{8'd10,  8'd240, 8'd100, 14'd5400,  8'd230, 2'd1, 1'b0, 8'd240};
    vecs[2]  = '{8'd30,  8'd90,  8'd250, 14'd3600,  8'd220, 2'd2, 1'b1, 8'd250};
    vecs[3]  = '{8'd180, 8'd180, 8'd20,  14'd9600,  8'd160, 2'd0, 1'b0, 8'd180};
    vecs[4]  = '{8'd77,  8'd77,  8'd77,  14'd0,     8'd0,   2'd0, 1'b0, 8'd77};
    vecs[5]  = '{8'd255, 8'd0,   8'd0,   14'd0,     8'd255, 2'd0, 1'b0, 8'd255};
    vecs[6]  = '{8'd255, 8'd0,   8'd255, 14'd15300, 8'd255, 2'd0, 1'b1, 8'd255};
    vecs[7]  = '{8'd0,   8'd0,   8'd0,   14'd0,     8'd0,   2'd0, 1'b0, 8'd0};
    vecs[8]  = '{8'd50,  8'd200, 8'd200, 14'd9000,  8'd150, 2'd1, 1'b0, 8'd200};
    vecs[9]  = '{8'd100, 8'd20,  8'd100, 14'd4800,  8'd80,  2'd0, 1'b1, 8'd100};
    vecs[10] = '{8'd0,   8'd255, 8'd0,   14'd0,     8'd255, 2'd1, 1'b0, 8'd255};
    vecs[11] = '{8'd0,   8'd0,   8'd1,   14'd0,     8'd1,   2'd2, 1'b0, 8'd1};

    rstN = 1'b0;
    inValid = 1'b0;
    inReady = 1'b1;
    inR = '0; inG = '0; inB = '0;
    #2 checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    latencyTest(0);
    applyStimulus(0, 12, 0, 0);
    applyStimulus(0, 6, 4, 3);

    // Two pixels in flight, then an asynchronous reset mid-cycle.
    @(negedge clk);
    inReady = 1'b0;
    inValid = 1'b1;
    driveVec(9);
    @(negedge clk);
    driveVec(10);
    @(negedge clk);
    inValid = 1'b0;
    #1 checkOutput("pre_reset_valid", 64'(outValid), 64'd1);
    #1 rstN = 1'b0;
    #1 checkResetOutputs("async_reset");
    @(negedge clk);
    rstN = 1'b1;
    inReady = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 checkOutput("no_replay", 64'(outValid), 64'd0);
    end
    latencyTest(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
